// File: rtl/bus_burst_arbiter.sv
// rtl/bus_burst_arbiter.sv - bus request/response bundle types and the read/write burst arbiter
// Separate round-robin grants for the read and write channels of one shared slave.

package bus_burst_arbiter_pkg;
   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic [4:0]  rlen;
      logic        rready;
      logic        awvalid;
      logic [31:0] waddr;
      logic [4:0]  wlen;
      logic        wlast;
      logic        wvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        bready;
   } bus_query_req_t;

   typedef struct packed {
      logic        rready;   // slave has accepted the read address
      logic        rvalid;
      logic [31:0] rdata;
      logic        rlast;
      logic        awready;
      logic        wready;
      logic        bvalid;
      logic [1:0]  bresp;
   } bus_query_resp_t;
endpackage

module bus_burst_arbiter
   import bus_burst_arbiter_pkg::*;
#(
   parameter int N_MASTER = 2,
   parameter int IDX_W    = $clog2(N_MASTER)
) (
   input  logic             clk,
   input  logic             rst,
   input  bus_query_req_t   m_req [N_MASTER],
   output bus_query_resp_t  m_resp [N_MASTER],
   output bus_query_req_t   s_req,
   input  bus_query_resp_t  s_resp,
   output logic [IDX_W-1:0] rd_owner,
   output logic             rd_busy,
   output logic [IDX_W-1:0] wr_owner,
   output logic             wr_busy,
   output logic             burst_err
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

   rd_state_t        rd_state, rd_state_n;
   wr_state_t        wr_state, wr_state_n;
   logic [IDX_W-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
   logic [IDX_W-1:0] rd_own_q, rd_own_n, wr_own_q, wr_own_n;
   logic [4:0]       rd_len, rd_len_n, wr_len, wr_len_n;
   logic [4:0]       rd_cnt, rd_cnt_n, wr_cnt, wr_cnt_n;
   logic             rd_err, wr_err, err_q;
   logic             rd_found, wr_found;
   logic [IDX_W-1:0] rd_pick, wr_pick;
   bus_query_req_t   rd_sel, wr_sel;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) == N_MASTER - 1) return '0;
      return i + 1'b1;
   endfunction

   // Zero-length requests are treated as not requesting, so the scan skips them.
   always_comb begin
      rd_found = 1'b0;
      rd_pick  = '0;
      wr_found = 1'b0;
      wr_pick  = '0;
      for (int k = 0; k < N_MASTER; k++) begin
         int jr;
         int jw;
         jr = int'(rd_ptr) + k;
         if (jr >= N_MASTER) jr = jr - N_MASTER;
         jw = int'(wr_ptr) + k;
         if (jw >= N_MASTER) jw = jw - N_MASTER;
         if (!rd_found && m_req[jr].arvalid && m_req[jr].rlen != 5'd0) begin
            rd_found = 1'b1;
            rd_pick  = IDX_W'(jr);
         end
         if (!wr_found && m_req[jw].awvalid && m_req[jw].wlen != 5'd0) begin
            wr_found = 1'b1;
            wr_pick  = IDX_W'(jw);
         end
      end
   end

   assign rd_sel = m_req[rd_own_q];
   assign wr_sel = m_req[wr_own_q];

   always_comb begin
      rd_state_n = rd_state;
      rd_ptr_n   = rd_ptr;
      rd_own_n   = rd_own_q;
      rd_len_n   = rd_len;
      rd_cnt_n   = rd_cnt;
      rd_err     = 1'b0;
      case (rd_state)
         R_IDLE: if (rd_found) begin
            rd_own_n   = rd_pick;
            rd_len_n   = m_req[rd_pick].rlen;
            rd_cnt_n   = '0;
            rd_state_n = R_ADDR;
         end
         R_ADDR: if (s_resp.rready) rd_state_n = R_DATA;
         R_DATA: if (s_resp.rvalid && rd_sel.rready) begin
            rd_cnt_n = rd_cnt + 5'd1;
            if (rd_cnt == rd_len) rd_err = 1'b1;
            if (s_resp.rlast) begin
               if (rd_cnt + 5'd1 != rd_len) rd_err = 1'b1;
               rd_state_n = R_IDLE;
               rd_ptr_n   = next_idx(rd_own_q);
            end
         end
         default: rd_state_n = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_n = wr_state;
      wr_ptr_n   = wr_ptr;
      wr_own_n   = wr_own_q;
      wr_len_n   = wr_len;
      wr_cnt_n   = wr_cnt;
      wr_err     = 1'b0;
      case (wr_state)
         W_IDLE: if (wr_found) begin
            wr_own_n   = wr_pick;
            wr_len_n   = m_req[wr_pick].wlen;
            wr_cnt_n   = '0;
            wr_state_n = W_ADDR;
         end
         W_ADDR: if (s_resp.awready) wr_state_n = W_DATA;
         W_DATA: if (wr_sel.wvalid && s_resp.wready) begin
            wr_cnt_n = wr_cnt + 5'd1;
            if (wr_cnt == wr_len) wr_err = 1'b1;
            if (wr_sel.wlast) begin
               if (wr_cnt + 5'd1 != wr_len) wr_err = 1'b1;
               wr_state_n = W_RESP;
            end
         end
         W_RESP: if (s_resp.bvalid && wr_sel.bready) begin
            wr_state_n = W_IDLE;
            wr_ptr_n   = next_idx(wr_own_q);
         end
         default: wr_state_n = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         rd_own_q <= '0;
         wr_own_q <= '0;
         rd_len   <= '0;
         wr_len   <= '0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_state <= rd_state_n;
         wr_state <= wr_state_n;
         rd_ptr   <= rd_ptr_n;
         wr_ptr   <= wr_ptr_n;
         rd_own_q <= rd_own_n;
         wr_own_q <= wr_own_n;
         rd_len   <= rd_len_n;
         wr_len   <= wr_len_n;
         rd_cnt   <= rd_cnt_n;
         wr_cnt   <= wr_cnt_n;
         err_q    <= rd_err | wr_err;
      end
   end

   assign rd_busy   = (rd_state != R_IDLE);
   assign wr_busy   = (wr_state != W_IDLE);
   assign rd_owner  = rd_own_q;
   assign wr_owner  = wr_own_q;
   assign burst_err = err_q;

   always_comb begin
      s_req = '0;
      if (rd_busy) begin
         s_req.arvalid = rd_sel.arvalid;
         s_req.araddr  = rd_sel.araddr;
         s_req.rlen    = rd_sel.rlen;
         s_req.rready  = rd_sel.rready;
      end
      if (wr_busy) begin
         s_req.awvalid = wr_sel.awvalid;
         s_req.waddr   = wr_sel.waddr;
         s_req.wlen    = wr_sel.wlen;
         s_req.wlast   = wr_sel.wlast;
         s_req.wvalid  = wr_sel.wvalid;
         s_req.wdata   = wr_sel.wdata;
         s_req.wstrb   = wr_sel.wstrb;
         s_req.bready  = wr_sel.bready;
      end
   end

   always_comb begin
      for (int i = 0; i < N_MASTER; i++) begin
         m_resp[i] = '0;
         if (rd_busy && rd_own_q == IDX_W'(i)) begin
            m_resp[i].rready = s_resp.rready;
            m_resp[i].rvalid = s_resp.rvalid;
            m_resp[i].rdata  = s_resp.rdata;
            m_resp[i].rlast  = s_resp.rlast;
         end
         if (wr_busy && wr_own_q == IDX_W'(i)) begin
            m_resp[i].awready = s_resp.awready;
            m_resp[i].wready  = s_resp.wready;
            m_resp[i].bvalid  = s_resp.bvalid;
            m_resp[i].bresp   = s_resp.bresp;
         end
      end
   end

endmodule

// File: doc/bus_burst_arbiter.md
BUS_BURST_ARBITER -- requirements
Module: bus_burst_arbiter

Interface
REQ-001 The block SHALL accept parameter N_MASTER, default 2, giving the number of bus masters (2..8).
REQ-002 The block SHALL accept parameter IDX_W, default $clog2(N_MASTER), giving the width of a master index.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port m_req, input, N_MASTER x bus_query_req_t: the request bundle from each master.
REQ-006 Port m_resp, output, N_MASTER x bus_query_resp_t: the response bundle to each master.
REQ-007 Port s_req, output, bus_query_req_t: the request bundle to the shared slave.
REQ-008 Port s_resp, input, bus_query_resp_t: the response bundle from the slave.
REQ-009 Port rd_owner, output, IDX_W bits: the master currently granted the read channel; valid while rd_busy=1.
REQ-010 Port rd_busy, output, 1 bit: read grant active.
REQ-011 Port wr_owner, output, IDX_W bits: the master currently granted the write channel; valid while wr_busy=1.
REQ-012 Port wr_busy, output, 1 bit: write grant active.
REQ-013 Port burst_err, output, 1 bit: one-cycle pulse flagging a burst-length protocol violation.

Function
REQ-014 The read and write channels SHALL be arbitrated independently and concurrently, with one grant per channel.
REQ-015 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA; write FSM states SHALL be W_IDLE, W_ADDR, W_DATA and W_RESP.
REQ-016 Round-robin arbitration:
- In R_IDLE, the grant goes to the first master with arvalid=1, scanning upward from rd_ptr and wrapping modulo N_MASTER.
- Write arbitration uses awvalid and wr_ptr in the same way.
REQ-017 On grant, the FSM SHALL:
- latch the owner and the request length (rlen or wlen);
- clear the beat counter;
- move R_IDLE->R_ADDR or W_IDLE->W_ADDR in the same cycle; arbitration costs 1 cycle.
REQ-018 A request with length 0 SHALL NOT be granted; it is ignored.
REQ-019 Routing while a channel is busy:
- s_req read fields (arvalid, araddr, rlen, rready) come from the read owner;
- s_req write fields (awvalid, waddr, wlen, wlast, wvalid, wdata, wstrb, bready) come from the write owner;
- each fed field is all-zero while its channel is idle.
REQ-020 m_resp routing:
- s_resp read fields go only to rd_owner;
- write fields go only to wr_owner;
- every other master sees all-zero response fields.
REQ-021 Read transitions:
- R_ADDR->R_DATA when s_resp.rready=1 (address accepted);
- each cycle with rvalid=1 and owner rready=1 counts one beat;
- R_DATA->R_IDLE on a counted beat with rlast=1.
REQ-022 Write transitions:
- W_ADDR->W_DATA when awready=1;
- each cycle with wvalid=1 and wready=1 counts one beat;
- W_DATA->W_RESP on a counted beat that has wlast=1;
- W_RESP->W_IDLE when bvalid=1 and bready=1.
REQ-023 Beat counters SHALL be 5 bits so a 16-beat burst counts without wrap.
REQ-024 burst_err SHALL pulse for 1 cycle when:
- rlast (or wlast) arrives on a beat count that differs from the latched length; or
- a beat arrives after the count already equals the latched length while the FSM is still in its data state.
The transaction still completes on last; burst_err does not change FSM flow.
REQ-025 On channel completion, the channel pointer SHALL become (owner+1) mod N_MASTER, and the next grant may issue in the following cycle.
REQ-026 An owner dropping its valid mid-transaction SHALL NOT release the grant; only completion releases it.
REQ-027 The same master SHALL be able to own the read and write channels simultaneously.

Reset
REQ-028 When rst=1 at a clock edge:
- both FSMs go to IDLE;
- rd_ptr=wr_ptr=0 and the beat counters are 0;
- rd_busy=wr_busy=0 and rd_owner=wr_owner=0;
- burst_err=0, s_req is all-zero and m_resp is all-zero.
REQ-029 A reset during any transaction SHALL abort it without a completion, with outputs at reset values the next cycle.

Verification
REQ-030 N_MASTER=2; master 0 and master 1 assert arvalid with rlen=4 in the same cycle after reset -> master 0 is granted; 4 beats with rlast on the 4th; R_IDLE; master 1 granted next cycle; no burst_err.
REQ-031 Three back-to-back read requests from both masters -> grants alternate 0,1,0; rd_ptr wraps from 1 to 0.
REQ-032 Master 1 writes wlen=16 while master 0 reads rlen=2 -> both channels are busy concurrently; 16 write beats then bvalid; W_IDLE only after the bvalid/bready handshake.
REQ-033 Read rlen=4 with the slave asserting rlast on beat 3 -> burst_err=1 for exactly 1 cycle; FSM returns to R_IDLE.
REQ-034 rst asserted while in W_DATA after 5 beats -> next cycle wr_busy=0, s_req=0 and counters=0; a new request is granted normally.
REQ-035 Master 1 requests with arvalid=1 and rlen=0 -> no grant, rd_busy stays 0.
